// File: rtl/serin_shift_receiver.sv
// Serial-input receive sequencer: SID synchroniser, start detect, LSB-first shift,
// stop check, SERIN holding register, done IRQ request and sticky error flags.
module serin_shift_receiver #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 sid,
  input  logic                 serEn,
  input  logic                 bitTick,
  input  logic                 serinRead,
  input  logic                 skresClr,
  output logic                 resyncReq,
  output logic [DATA_BITS-1:0] serinData,
  output logic                 serinDone,
  output logic                 busy,
  output logic                 framerErr,
  output logic                 overrunErr
);

  // state | meaning
  // IDLE  | waiting for a falling edge on sidS
  // START | start bit seen, confirm it low at the first tick
  // DATA  | shifting data bits, one per tick
  // STOP  | sample stop bit, load SERIN
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sid_p_q;
  logic [1:0]             state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   done_q, resync_q, full_q, fe_q, ovr_q;
  logic                   full_d, fe_d, ovr_d;
  logic                   sid_s, start_edge, load;

  assign sid_s      = sync_q[SYNC_STAGES-1];
  assign start_edge = sid_p_q & ~sid_s;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (bitTick) state_d = sid_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bitTick) begin
          shift_d = {sid_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = ST_STOP;
        end
      end
      default: begin
        if (bitTick) begin
          load    = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
    // Disabling mid-frame drops the frame without touching SERIN or the flags
    if (!serEn) begin
      state_d = ST_IDLE;
      shift_d = '0;
      cnt_d   = '0;
      load    = 1'b0;
    end
  end

  assign data_d = load ? shift_q : data_q;
  assign full_d = load | (full_q & ~serinRead);
  assign fe_d   = (load & ~sid_s) | (fe_q & ~skresClr);
  assign ovr_d  = (load & full_q & ~serinRead) | (ovr_q & ~skresClr);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync_q   <= '1;
      sid_p_q  <= 1'b1;
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      resync_q <= 1'b0;
      full_q   <= 1'b0;
      fe_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sid};
      sid_p_q  <= sid_s;
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      done_q   <= load;
      resync_q <= (state_q == ST_IDLE) & start_edge;
      full_q   <= full_d;
      fe_q     <= fe_d;
      ovr_q    <= ovr_d;
    end
  end

  assign resyncReq  = resync_q;
  assign serinData  = data_q;
  assign serinDone  = done_q;
  assign busy       = (state_q != ST_IDLE);
  assign framerErr  = fe_q;
  assign overrunErr = ovr_q;

endmodule
